// File: rtl/proc_issue_arbiter_pkg.sv
// proc_issue_pkg: shared definitions for the processor issue arbiter.
//   - opcode constants (instruction bits [15:13])
//   - FSM state encoding
//   - default hold-cycle counts and the opcode -> hold-cycle mapping
package proc_issue_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int DEF_MV_CYCLES  = 2;
    localparam int DEF_ALU_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RETIRE
    } state_t;

    // Opcodes 1xx are reserved; they get the short (mv) hold time.
    function automatic int hold_cycles(input logic [2:0] op, input int mv, input int alu);
        case (op)
            OP_MV, OP_MVI: return mv;
            OP_ADD, OP_SUB: return alu;
            default: return mv;
        endcase
    endfunction

endpackage

// File: rtl/proc_issue_arbiter_if.sv
// proc_issue_arbiter_if: requester handshakes plus processor-side pins.
//   master : instruction sources / processor model (drive valid, instr, proc_bus)
//   slave  : the arbiter (drives ready, done, result, proc_iin, busy)
interface proc_issue_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_instr;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_instr;
    logic        req1_ready;
    logic        done0;
    logic        done1;
    logic [15:0] result;
    logic [15:0] proc_iin;
    logic [15:0] proc_bus;
    logic        busy;

    modport master (
        output req0_valid, req0_instr, req1_valid, req1_instr, proc_bus,
        input  req0_ready, req1_ready, done0, done1, result, proc_iin, busy
    );

    modport slave (
        input  req0_valid, req0_instr, req1_valid, req1_instr, proc_bus,
        output req0_ready, req1_ready, done0, done1, result, proc_iin, busy
    );
endinterface

// File: rtl/proc_issue_arbiter_rr_arb2.sv
// rr_arb2: 2-way grant logic.
//   clock, resetn : clock, synchronous active-high reset
//   en            : grants allowed this cycle
//   valid[1:0]    : request lines
//   gnt[1:0]      : one-hot (or zero) combinational grant
// Default: round-robin on ties using a last-grant pointer (reset to 1 so
// req0 wins the first tie). With ARB_FIXED_PRIORITY_EN defined, req0
// always wins and the pointer is not kept.
module rr_arb2 (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] gnt
);

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (valid[0])      gnt = 2'b01;
            else if (valid[1]) gnt = 2'b10;
        end
    end
`else
    logic last1;  // 1 = requester 1 was granted last

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&valid) gnt = last1 ? 2'b01 : 2'b10;
            else        gnt = valid;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn)    last1 <= 1'b1;
        else if (|gnt) last1 <= gnt[1];
    end
`endif

endmodule

// File: rtl/proc_issue_arbiter.sv
// proc_issue_arbiter: shares one processor datapath between two requesters.
//   clock  : rising-edge clock
//   resetn : synchronous, active-high reset
//   bus    : proc_issue_arbiter_if.slave (req0/1 valid/instr/ready,
//            done0/1, result, proc_iin, proc_bus, busy)
// A granted instruction is driven on proc_iin for its hold time, proc_bus
// is captured on the last hold cycle, and a done pulse with the result
// goes to the owner in the following RETIRE cycle.
// Optional macro ARB_FIXED_PRIORITY_EN: req0 always wins ties.
// MV_CYCLES and ALU_CYCLES must both be >= 1.
module proc_issue_arbiter
    import proc_issue_pkg::*;
#(
    parameter int          MV_CYCLES  = DEF_MV_CYCLES,
    parameter int          ALU_CYCLES = DEF_ALU_CYCLES,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input logic                 clock,
    input logic                 resetn,
    proc_issue_arbiter_if.slave bus
);

    localparam int MAX_CYCLES = (MV_CYCLES > ALU_CYCLES) ? MV_CYCLES : ALU_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner;     // 1 = requester 1 owns the in-flight instruction
    logic [15:0]   iin_q;     // latched instruction, doubles as proc_iin
    logic [15:0]   result_q;
    logic          done0_q;
    logic          done1_q;
    logic          busy_q;

    logic [1:0]    valid;
    logic [1:0]    gnt;
    logic          arb_en;
    logic [15:0]   sel_instr;

    assign valid  = {bus.req1_valid, bus.req0_valid};
    // No grants while reset is asserted, nor outside IDLE.
    assign arb_en = (state == IDLE) && !resetn;

    rr_arb2 u_arb (
        .clock (clock),
        .resetn(resetn),
        .en    (arb_en),
        .valid (valid),
        .gnt   (gnt)
    );

    assign sel_instr = gnt[1] ? bus.req1_instr : bus.req0_instr;

    always_ff @(posedge clock) begin
        if (resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            iin_q    <= NOP_INSTR;
            result_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        owner  <= gnt[1];
                        cnt    <= CW'(hold_cycles(sel_instr[15:13], MV_CYCLES, ALU_CYCLES));
                        iin_q  <= sel_instr;
                        busy_q <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 1'b1;
                    // Last hold cycle: bus reflects the instruction's effect.
                    if (cnt == CW'(1)) begin
                        result_q <= bus.proc_bus;
                        iin_q    <= NOP_INSTR;
                        busy_q   <= 1'b0;
                        done0_q  <= !owner;
                        done1_q  <= owner;
                        state    <= RETIRE;
                    end
                end
                RETIRE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.result     = result_q;
    assign bus.proc_iin   = iin_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_proc_issue_arbiter.sv
// Self-checking bench for proc_issue_arbiter: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against a timestamp-based transaction model.
module tb_proc_issue_arbiter;

    localparam int          MV   = 2;
    localparam int          ALU  = 4;
    localparam logic [15:0] NOP  = 16'h0000;
`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit          FIXED = 1'b1;
`else
    localparam bit          FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    proc_issue_arbiter_if ifc ();

    proc_issue_arbiter #(
        .MV_CYCLES (MV),
        .ALU_CYCLES(ALU),
        .NOP_INSTR (NOP)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (ifc)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    // Transaction model: one in-flight instruction described by its accept
    // cycle and hold length; everything else follows from the timeline.
    bit          m_inflight = 1'b0;
    int          m_own, m_t, m_n, m_g;
    logic [15:0] m_instr;
    logic [15:0] m_result = 16'h0;
    bit          m_last1 = 1'b1;

    logic        s_rdy0, s_rdy1, s_done0, s_done1, s_busy;
    logic [15:0] s_iin, s_result;

    function automatic int model_n(input logic [15:0] ins);
        if (ins[15:14] == 2'b01) return ALU;   // add / sub
        return MV;                             // mv, mvi, reserved 1xx
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit v0, input logic [15:0] i0, input bit v1,
                        input logic [15:0] i1, input logic [15:0] bv, input bit rst);
        bit          free, hold, ret;
        logic [15:0] e_iin;
        @(posedge clock);
        #1;
        ifc.req0_valid = v0;
        ifc.req0_instr = i0;
        ifc.req1_valid = v1;
        ifc.req1_instr = i1;
        ifc.proc_bus   = bv;
        resetn         = rst;
        @(negedge clock);
        s_rdy0 = ifc.req0_ready;  s_rdy1 = ifc.req1_ready;
        s_done0 = ifc.done0;      s_done1 = ifc.done1;
        s_busy = ifc.busy;        s_iin = ifc.proc_iin;
        s_result = ifc.result;

        hold = m_inflight && cyc >= m_t + 1 && cyc <= m_t + m_n;
        ret  = m_inflight && cyc == m_t + m_n + 1;
        free = !m_inflight || cyc >= m_t + m_n + 2;
        e_iin = hold ? m_instr : NOP;
        m_g = -1;
        if (!rst && free) begin
            if (v0 && v1)  m_g = (FIXED || m_last1) ? 0 : 1;
            else if (v0)   m_g = 0;
            else if (v1)   m_g = 1;
        end

        if (chk_on) begin
            chk("req0_ready", {15'h0, s_rdy0}, {15'h0, m_g == 0});
            chk("req1_ready", {15'h0, s_rdy1}, {15'h0, m_g == 1});
            chk("done0", {15'h0, s_done0}, {15'h0, ret && m_own == 0});
            chk("done1", {15'h0, s_done1}, {15'h0, ret && m_own == 1});
            chk("busy", {15'h0, s_busy}, {15'h0, hold});
            chk("proc_iin", s_iin, e_iin);
            chk("result", s_result, m_result);
        end

        if (rst) begin
            m_inflight = 1'b0;
            m_last1    = 1'b1;
            m_result   = 16'h0;
        end else begin
            if (m_inflight && cyc == m_t + m_n) m_result = bv;
            if (m_g >= 0) begin
                m_inflight = 1'b1;
                m_own      = m_g;
                m_t        = cyc;
                m_instr    = (m_g == 1) ? i1 : i0;
                m_n        = model_n(m_instr);
                if (!FIXED) m_last1 = (m_g == 1);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 16'h0, 0, 16'h0, 16'h0, 0);
    endtask

    bit          pend0, pend1;
    logic [15:0] ins0, ins1;

    initial begin
        ifc.req0_valid = 0; ifc.req1_valid = 0;
        ifc.req0_instr = 0; ifc.req1_instr = 0; ifc.proc_bus = 0;
        step(0, 16'h0, 0, 16'h0, 16'h0, 1);
        chk_on = 1'b1;
        step(0, 16'h0, 0, 16'h0, 16'h0, 1);
        // reset state
        chk("rst_iin", s_iin, NOP);
        chk("rst_result", s_result, 16'h0);
        idle(1);

        // req0 mvi: ready at T, held 2 cycles, done0 at T+3
        step(1, 16'h2400, 0, 16'h0, 16'h0005, 0);
        chk("d1_rdy0", {15'h0, s_rdy0}, 16'h1);
        for (int k = 1; k <= 3; k++) begin
            step(0, 16'h0, 0, 16'h0, 16'h0005, 0);
            if (k <= 2) chk("d1_iin", s_iin, 16'h2400);
            else begin
                chk("d1_done0", {15'h0, s_done0}, 16'h1);
                chk("d1_result", s_result, 16'h0005);
                chk("d1_iin_nop", s_iin, NOP);
            end
        end
        idle(1);

        // req1 add: held 4 cycles, bus valid only on last hold cycle
        step(0, 16'h0, 1, 16'h4080, 16'h0, 0);
        chk("d2_rdy1", {15'h0, s_rdy1}, 16'h1);
        for (int k = 1; k <= 5; k++) begin
            step(0, 16'h0, 0, 16'h0, (k == 4) ? 16'h0009 : 16'h0, 0);
            if (k <= 4) chk("d2_iin", s_iin, 16'h4080);
            else begin
                chk("d2_done1", {15'h0, s_done1}, 16'h1);
                chk("d2_done0", {15'h0, s_done0}, 16'h0);
                chk("d2_result", s_result, 16'h0009);
            end
        end

        // both valid continuously after reset
        step(0, 16'h0, 0, 16'h0, 16'h0, 1);
        for (int i = 0; i < 12; i++) begin
            step(1, 16'h0000, 1, 16'h0000, 16'h0, 0);
            chk("d3_rdy0", {15'h0, s_rdy0},
                {15'h0, (i % 4 == 0) && (FIXED || i % 8 == 0)});
            chk("d3_rdy1", {15'h0, s_rdy1},
                {15'h0, !FIXED && (i % 8 == 4)});
            if (i % 4 == 3) chk("d3_retire_nop", s_iin, NOP);
        end
        step(0, 16'h0, 1, 16'h0000, 16'h0, 0);
        chk("d3_rdy1_after_drop", {15'h0, s_rdy1}, 16'h1);
        idle(4);

        // reset during 2nd hold cycle of an add; req1 pending
        step(1, 16'h4080, 0, 16'h0, 16'h0, 0);
        chk("d4_rdy0", {15'h0, s_rdy0}, 16'h1);
        step(0, 16'h0, 1, 16'h2001, 16'h0, 0);
        step(0, 16'h0, 1, 16'h2001, 16'h0, 1);
        chk("d4_busy_in_rst", {15'h0, s_busy}, 16'h1);
        step(0, 16'h0, 1, 16'h2001, 16'h0, 0);
        chk("d4_iin_nop", s_iin, NOP);
        chk("d4_busy0", {15'h0, s_busy}, 16'h0);
        chk("d4_rdy1", {15'h0, s_rdy1}, 16'h1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 16'h0, 0, 16'h0, 16'h0, 0);
            chk("d4_no_done0", {15'h0, s_done0}, 16'h0);
            if (k == 3) chk("d4_done1", {15'h0, s_done1}, 16'h1);
        end

        // reserved opcode 111: minimum hold, normal retire
        step(1, 16'hE000, 0, 16'h0, 16'h0, 0);
        chk("d5_rdy0", {15'h0, s_rdy0}, 16'h1);
        for (int k = 1; k <= 3; k++) begin
            step(0, 16'h0, 0, 16'h0, 16'h00E7, 0);
            if (k <= 2) chk("d5_iin", s_iin, 16'hE000);
            else begin
                chk("d5_done0", {15'h0, s_done0}, 16'h1);
                chk("d5_result", s_result, 16'h00E7);
            end
        end

        // randomized traffic
        pend0 = 0; pend1 = 0; ins0 = 0; ins1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend0 && $urandom_range(2) == 0) begin pend0 = 1; ins0 = 16'($urandom); end
            else if (pend0 && $urandom_range(24) == 0) pend0 = 0;
            else if (pend0 && $urandom_range(15) == 0) ins0 = 16'($urandom);
            if (!pend1 && $urandom_range(2) == 0) begin pend1 = 1; ins1 = 16'($urandom); end
            else if (pend1 && $urandom_range(24) == 0) pend1 = 0;
            else if (pend1 && $urandom_range(15) == 0) ins1 = 16'($urandom);
            step(pend0, ins0, pend1, ins1, 16'($urandom), $urandom_range(149) == 0);
            if (m_g == 0) pend0 = 0;
            if (m_g == 1) pend1 = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
